// File: rtl/ipa_pkg.sv
// Shared types and constants for the input port adapter.
package ipa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } rx_state_e;

  typedef enum logic {
    PH_LO,
    PH_HI
  } phase_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned WORD_W    = 16;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  typedef logic [DATA_BITS-1:0] byte_t;
  typedef logic [WORD_W-1:0]    word_t;

  function automatic word_t pack_word(input byte_t hi, input byte_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ipa_if.sv
// Bus side of the adapter: master holds cyc_i, adapter returns ack_o/dat_o.
interface ipa_if;
  import ipa_pkg::*;

  logic  cyc_i;
  logic  ack_o;
  word_t dat_o;

  modport slave  (input cyc_i, output ack_o, output dat_o);
  modport master (output cyc_i, input ack_o, input dat_o);

endinterface

// File: rtl/ipa_rx.sv
// Strobed serial receiver: synchronisers, strobe edge detect and frame FSM.
module ipa_rx
  import ipa_pkg::*;
(
  input  logic  clk_i,
  input  logic  reset_i,
  input  logic  txd_i,
  input  logic  txc_i,
  output logic  byte_done_o,
  output byte_t byte_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic      txd_s1_q, txd_s2_q, txc_s1_q, txc_s2_q;
  rx_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  byte_t     shift_q, shift_d;
  logic      done_q, done_d;
  byte_t     byte_q, byte_d;
  logic      bit_evt, bit_val;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      txd_s1_q <= 1'b1;
      txd_s2_q <= 1'b1;
      txc_s1_q <= 1'b0;
      txc_s2_q <= 1'b0;
    end else begin
      txd_s1_q <= txd_i;
      txd_s2_q <= txd_s1_q;
      txc_s1_q <= txc_i;
      txc_s2_q <= txc_s1_q;
    end
  end

  // Data is taken from the first stage so it lines up with the strobe edge.
  assign bit_evt = txc_s1_q & ~txc_s2_q;
  assign bit_val = txd_s1_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bit_evt) begin
      unique case (state_q)
        IDLE:    if (bit_val == START_BIT) state_d = DATA;
        DATA:    if (cnt_q == LAST_BIT) state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    byte_d  = byte_q;
    if (bit_evt) begin
      unique case (state_q)
        IDLE: cnt_d = '0;
        DATA: begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 4'd1;
        end
        STOP: begin
          if (bit_val == STOP_BIT) begin
            done_d = 1'b1;
            byte_d = shift_q;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      byte_q  <= byte_d;
    end
  end

  assign byte_done_o = done_q;
  assign byte_o      = byte_q;

endmodule

// File: rtl/ipa.sv
// Input port adapter: packs received byte pairs into words for a bus master.
module ipa
  import ipa_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     txd_i,
  input  logic     txc_i,
  ipa_if.slave     bus
);

  logic   byte_done;
  byte_t  rx_byte;
  phase_e phase_q, phase_d;
  byte_t  lo_q, lo_d;
  logic   word_done;
  word_t  word;
  logic   ack_q, ack_d;
  word_t  dat_q, dat_d;

  ipa_rx u_rx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .txd_i       (txd_i),
    .txc_i       (txc_i),
    .byte_done_o (byte_done),
    .byte_o      (rx_byte)
  );

  assign word_done = byte_done & bus.cyc_i & (phase_q == PH_HI);
  assign word      = pack_word(rx_byte, lo_q);

  // Dropping cyc_i abandons any half-built word; bytes arriving then are lost.
  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    if (!bus.cyc_i) begin
      phase_d = PH_LO;
    end else if (byte_done) begin
      if (phase_q == PH_LO) begin
        lo_d    = rx_byte;
        phase_d = PH_HI;
      end else begin
        phase_d = PH_LO;
      end
    end
  end

  always_comb begin
    ack_d = word_done & bus.cyc_i;
    dat_d = ack_d ? word : '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_q <= PH_LO;
      lo_q    <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_ipa.sv
// Self-checking bench for ipa: directed scenarios then randomized frames against a frame-level model.
module tb_ipa;

  logic clk = 1'b0;
  logic rst_n;
  logic txd, txc;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic rand_timing = 1'b0;
  logic prev_ack = 1'b0;

  // Reference model: at most one pending low byte, cleared whenever cyc is low.
  logic        have_lo = 1'b0;
  logic [7:0]  lo_byte = '0;

  ipa_if bus ();

  ipa dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .txd_i   (txd),
    .txc_i   (txc),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      if (!bus.ack_o) check("dat_idle_zero", 32'(bus.dat_o), 32'h0);
      else check("ack_single_cycle", 32'(prev_ack), 32'h0);
      prev_ack = bus.ack_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    int unsigned hi, lo;
    hi = rand_timing ? $urandom_range(1, 2) : 1;
    lo = rand_timing ? $urandom_range(1, 3) : 1;
    txd = v;
    txc = 1'b1;
    repeat (hi) tick();
    txc = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic set_cyc(input logic v);
    bus.cyc_i = v;
    if (!v) have_lo = 1'b0;
    tick();
  endtask

  // Stop bit uses fixed 1-high/1-low timing so the ack latency is exact.
  task automatic send_frame(input logic [7:0] b, input logic good);
    logic        exp_ack;
    logic [15:0] exp_dat;
    exp_ack = 1'b0;
    exp_dat = '0;
    if (good) begin
      if (!bus.cyc_i) begin
        have_lo = 1'b0;
      end else if (have_lo) begin
        exp_ack = 1'b1;
        exp_dat = {b, lo_byte};
        have_lo = 1'b0;
      end else begin
        lo_byte = b;
        have_lo = 1'b1;
      end
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    txd = good;
    txc = 1'b1;
    tick();
    txc = 1'b0;
    txd = 1'b1;
    tick();
    tick();
    check("frame_ack", 32'(bus.ack_o), 32'(exp_ack));
    check("frame_dat", 32'(bus.dat_o), 32'(exp_dat));
    tick();
    check("post_ack", 32'(bus.ack_o), 32'h0);
    check("post_dat", 32'(bus.dat_o), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'h0);
    check("rst_dat", 32'(bus.dat_o), 32'h0);
    txc = 1'b0;
    txd = 1'b1;
    have_lo = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    txd = 1'b1;
    txc = 1'b0;
    bus.cyc_i = 1'b0;
    #12;
    check("reset_ack", 32'(bus.ack_o), 32'h0);
    check("reset_dat", 32'(bus.dat_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // cyc low: every byte is discarded
    for (int i = 0; i < 4; i++) send_frame(8'h00, 1'b1);

    do_reset();
    set_cyc(1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);

    // one-clock cyc drop loses the pending low byte
    send_frame(8'hAA, 1'b1);
    set_cyc(1'b0);
    set_cyc(1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b1);

    // framing error discards only the bad byte
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);

    // reset after four data bits of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    do_reset();
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);

    rand_timing = 1'b1;
    for (int n = 0; n < 160; n++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 2) set_cyc(~bus.cyc_i);
      else if (r < 4 && bus.cyc_i) begin
        set_cyc(1'b0);
        set_cyc(1'b1);
      end else if (r < 6) send_bit(1'b1);
      else if (r == 6) begin
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        do_reset();
      end
      if (r == 7) set_cyc(1'b1);
      repeat ($urandom_range(0, 3)) tick();
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
